// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable divider, oversampling, width, parity and stop bits,
// mid-bit sampling on an oversample tick, single-entry valid/ready output register.
//
// state  | meaning
// IDLE   | waiting for a falling edge on rx_s (needs rx_en and armed)
// START  | confirming the start bit at its midpoint
// DATA   | sampling DATA_BITS data bits, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling stop bits; commits on the last one
module uart_rx_param #(
    parameter int CLK_DIV    = 78,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 hwclk,
    input  logic                 reset_n,
    input  logic                 rx,
    input  logic                 rx_en,
    output logic [DATA_BITS-1:0] rxbyte,
    output logic                 rxvalid,
    input  logic                 rxready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] TICK_LAST  = CW'(CLK_DIV - 1);
    localparam logic [SW-1:0] MID_START  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] BIT_LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
    localparam logic          PAR_TARGET = (PARITY == 1);
    localparam logic          STOP_LAST  = (STOP_BITS == 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CW-1:0]        tcnt;
    logic [SW-1:0]        scnt;
    logic [BW-1:0]        bcnt;
    logic                 stop_idx;
    logic                 armed;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr;
    logic                 perr;

    logic tick;
    logic start_acc;
    logic samp_mid;
    logic commit;
    logic ferr_final;

    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        tick       = (tcnt == TICK_LAST);
        start_acc  = (state == S_IDLE) && rx_en && armed && !rx_s;
        samp_mid   = tick && (scnt == BIT_LAST);
        commit     = (state == S_STOP) && samp_mid && (stop_idx == STOP_LAST);
        ferr_final = ferr | ~rx_s;
    end

    assign busy = (state != S_IDLE);

    // Restarting the divider on start acceptance phase-aligns every tick to the falling edge.
    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt <= '0;
        end else if (start_acc || tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            scnt     <= '0;
            bcnt     <= '0;
            stop_idx <= 1'b0;
            armed    <= 1'b1;
            shreg    <= '0;
            ferr     <= 1'b0;
            perr     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_s) begin
                        armed <= 1'b1;
                    end
                    if (start_acc) begin
                        state    <= S_START;
                        scnt     <= '0;
                        bcnt     <= '0;
                        stop_idx <= 1'b0;
                        armed    <= 1'b0;
                        ferr     <= 1'b0;
                        perr     <= 1'b0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (scnt == MID_START) begin
                            scnt  <= '0;
                            state <= rx_s ? S_IDLE : S_DATA;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (samp_mid) begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        scnt  <= '0;
                        bcnt  <= bcnt + 1'b1;
                        if (bcnt == DATA_LAST) begin
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end else if (tick) begin
                        scnt <= scnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (samp_mid) begin
                        perr  <= ((^shreg) ^ rx_s) != PAR_TARGET;
                        scnt  <= '0;
                        state <= S_STOP;
                    end else if (tick) begin
                        scnt <= scnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (samp_mid) begin
                        ferr     <= ferr_final;
                        scnt     <= '0;
                        stop_idx <= 1'b1;
                        if (stop_idx == STOP_LAST) begin
                            state <= S_IDLE;
                        end
                    end else if (tick) begin
                        scnt <= scnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A commit while an unaccepted word is held drops the new frame instead of overwriting.
    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) begin
            rxbyte     <= '0;
            rxvalid    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (commit) begin
                if (rxvalid && !rxready) begin
                    overrun <= 1'b1;
                end else begin
                    rxbyte     <= shreg;
                    frame_err  <= ferr_final;
                    parity_err <= perr;
                    rxvalid    <= 1'b1;
                end
            end else if (rxvalid && rxready) begin
                rxvalid <= 1'b0;
            end
        end
    end

endmodule
